// File: rtl/uart_program_loader.sv
`default_nettype none
// uart_program_loader: framed UART program-image loader writing 32-bit words into IM/DM, rev 1.0.
// Define LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte on every frame.
module uart_program_loader #(
  parameter int ADDR_W         = 12,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int               GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [15:0]      MAX_LEN  = 16'(MAX_WORDS);
  localparam logic [7:0]       SYNC     = 8'hA5;
  localparam logic [7:0]       ACK      = 8'h06;
  localparam logic [7:0]       NAK      = 8'h15;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, TGT = 3'd1, LEN_LO = 3'd2, LEN_HI = 3'd3, DATA = 3'd4, CKSUM = 3'd5, RESP = 3'd6
  } state_t;
  logic [7:0]  sum;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, TGT = 3'd1, LEN_LO = 3'd2, LEN_HI = 3'd3, DATA = 3'd4, RESP = 3'd6
  } state_t;
`endif

  state_t            state;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [GAP_W-1:0]  gap;
  logic              started;
  logic [15:0]       rx_len;

  assign rx_len = {rx_data, len[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      gap        <= '0;
      started    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      mem_we     <= 1'b0;
      mem_sel    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      // Let a preloaded image run as soon as reset is released.
      if (!started) begin
        started    <= 1'b1;
        core_rst_n <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (rx_valid && rx_data == SYNC) begin
            state      <= TGT;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            core_rst_n <= 1'b0;
            gap        <= '0;
          end
        end
        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
            if (tx_data == ACK) begin
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: begin
          if (rx_valid) begin
            gap <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum <= (state == TGT) ? rx_data : sum + rx_data;
`endif
            case (state)
              TGT: begin
                mem_sel <= rx_data[0];
                if (rx_data > 8'd1) begin
                  state <= RESP; tx_valid <= 1'b1; tx_data <= NAK;
                end else begin
                  state <= LEN_LO;
                end
              end
              LEN_LO: begin
                len[7:0] <= rx_data;
                state    <= LEN_HI;
              end
              LEN_HI: begin
                len[15:8] <= rx_data;
                word_cnt  <= '0;
                byte_cnt  <= '0;
                if (rx_len > MAX_LEN) begin
                  state <= RESP; tx_valid <= 1'b1; tx_data <= NAK;
                end else if (rx_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= CKSUM;
`else
                  state <= RESP; tx_valid <= 1'b1; tx_data <= ACK;
`endif
                end else begin
                  state <= DATA;
                end
              end
              DATA: begin
                // Bytes arrive LSB first; the 4th byte completes the word.
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= {rx_data, word_buf[23:8]};
                if (byte_cnt == 2'd3) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= {rx_data, word_buf};
                  mem_addr  <= {word_cnt[ADDR_W-3:0], 2'b00};
                  word_cnt  <= word_cnt + 16'd1;
                  if (word_cnt == len - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    state <= CKSUM;
`else
                    state <= RESP; tx_valid <= 1'b1; tx_data <= ACK;
`endif
                  end
                end
              end
`ifdef LOADER_CHECKSUM_EN
              CKSUM: begin
                state    <= RESP;
                tx_valid <= 1'b1;
                tx_data  <= ((sum + rx_data) == 8'h00) ? ACK : NAK;
              end
`endif
              default: ;
            endcase
          end else if (gap == GAP_LAST) begin
            state <= RESP; tx_valid <= 1'b1; tx_data <= NAK;
          end else begin
            gap <= gap + GAP_ONE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_program_loader.sv
`default_nettype none
// tb_uart_program_loader: directed and randomized frames checked against a frame-level model.
module tb_uart_program_loader;
  localparam int TO = 300;

  logic        clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid, mem_we, mem_sel, core_rst_n, busy, done, error;
  logic [7:0]  tx_data;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;

  uart_program_loader #(.ADDR_W(12), .MAX_WORDS(1024), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst_n(core_rst_n),
    .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0]  fq[$];
  logic [31:0] words[$];
  logic [11:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_ack;
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        wr_sel[$];
  logic [7:0]  tx_q[$];

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata); wr_sel.push_back(mem_sel);
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_sel.delete(); tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b; tick(1); rx_valid = 1'b0; tick(gap);
  endtask

  task automatic send_frame(input int maxgap);
    foreach (fq[i]) send_byte(fq[i], $urandom_range(0, maxgap));
  endtask

  task automatic wait_tx(input int budget, output logic [7:0] b, output bit ok);
    ok = 0; b = 8'h00;
    for (int i = 0; i < budget; i++) begin
      if (tx_q.size() > 0) begin b = tx_q.pop_front(); ok = 1; break; end
      tick(1);
    end
    tick(2);
  endtask

  // Frame model: bytes on the wire plus the writes and response the loader should produce.
  task automatic build_frame(input logic [7:0] tgt, input logic [15:0] len, input logic [7:0] bad);
    logic [7:0] s, b;
    fq.delete(); exp_addr.delete(); exp_data.delete();
    fq.push_back(8'hA5); fq.push_back(tgt); fq.push_back(len[7:0]); fq.push_back(len[15:8]);
    s = tgt + len[7:0] + len[15:8];
    foreach (words[i]) for (int k = 0; k < 4; k++) begin
      b = words[i][8*k +: 8]; fq.push_back(b); s = s + b;
    end
`ifdef LOADER_CHECKSUM_EN
    b = 8'h00 - s + bad; fq.push_back(b);
`endif
    exp_ack = (tgt <= 8'd1) && (len <= 16'd1024) && (bad == 8'h00);
    if (tgt <= 8'd1 && len <= 16'd1024)
      foreach (words[i]) begin exp_addr.push_back(12'(4 * i)); exp_data.push_back(words[i]); end
  endtask

  task automatic load_frame1();
    words.delete(); words.push_back(32'h0000_0013); words.push_back(32'h0000_006F);
    build_frame(8'h00, 16'd2, 8'h00);
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({tx_valid, tx_data, mem_we, mem_sel, mem_addr, mem_wdata, busy, done, error, core_rst_n} !== 59'd0) begin
      failures++; $display("FAIL reset_values got tx_valid=%b tx_data=%h we=%b addr=%h wdata=%h busy=%b done=%b err=%b core=%b want all 0",
        tx_valid, tx_data, mem_we, mem_addr, mem_wdata, busy, done, error, core_rst_n);
    end
    rst_n = 1'b1; tick(1);
    checks++;
    if (core_rst_n !== 1'b1) begin failures++; $display("FAIL reset_release core_rst_n=%b want 1", core_rst_n); end
  endtask

  task automatic test_frame1();
    logic [7:0] r; bit ok;
    load_frame1(); clear_mon();
    foreach (fq[i]) begin
      send_byte(fq[i], 1);
      if (i == 0) begin
        checks++;
        if (core_rst_n !== 1'b0 || busy !== 1'b1) begin
          failures++; $display("FAIL frame1_start core_rst_n=%b busy=%b want 0 1", core_rst_n, busy);
        end
      end
    end
    wait_tx(50, r, ok);
    checks++;
    if (!ok || r !== 8'h06) begin failures++; $display("FAIL frame1_tx got %h (seen=%0d) want 06", r, ok); end
    checks++;
    if (wr_addr.size() != 2) begin failures++; $display("FAIL frame1_nwrites got %0d want 2", wr_addr.size()); end
    else begin
      checks++;
      if (wr_addr[0] !== 12'h000 || wr_data[0] !== 32'h13 || wr_addr[1] !== 12'h004 ||
          wr_data[1] !== 32'h6F || wr_sel[0] !== 1'b0 || wr_sel[1] !== 1'b0) begin
        failures++; $display("FAIL frame1_writes got %h=%h %h=%h sel=%b%b want 000=00000013 004=0000006f sel=00",
          wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_sel[0], wr_sel[1]);
      end
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || core_rst_n !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL frame1_status done=%b err=%b core=%b busy=%b want 1 0 1 0", done, error, core_rst_n, busy);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_cksum();
    logic [7:0] r; bit ok;
    load_frame1(); fq[fq.size()-1] = 8'h7D; clear_mon();
    send_frame(2); wait_tx(50, r, ok);
    checks++;
    if (!ok || r !== 8'h15) begin failures++; $display("FAIL badck_tx got %h want 15", r); end
    checks++;
    if (wr_addr.size() != 2) begin failures++; $display("FAIL badck_nwrites got %0d want 2", wr_addr.size()); end
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || core_rst_n !== 1'b0) begin
      failures++; $display("FAIL badck_status err=%b done=%b core=%b want 1 0 0", error, done, core_rst_n);
    end
  endtask
`endif

  task automatic test_len_too_big();
    logic [7:0] r; bit ok;
    clear_mon();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h04, 0);
    wait_tx(3, r, ok);
    checks++;
    if (!ok || r !== 8'h15) begin failures++; $display("FAIL lenbig_tx got %h (seen=%0d) want 15", r, ok); end
    checks++;
    if (wr_addr.size() != 0 || error !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL lenbig_status writes=%0d err=%b done=%b want 0 1 0", wr_addr.size(), error, done);
    end
  endtask

  task automatic test_bad_target();
    logic [7:0] r; bit ok;
    clear_mon(); send_byte(8'hA5, 0); send_byte(8'h02, 0);
    wait_tx(5, r, ok);
    checks++;
    if (!ok || r !== 8'h15 || error !== 1'b1 || wr_addr.size() != 0) begin
      failures++; $display("FAIL badtgt got tx=%h err=%b writes=%0d want 15 1 0", r, error, wr_addr.size());
    end
  endtask

  task automatic test_timeout();
    int n; logic [7:0] r; bit ok;
    clear_mon();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h01, 0);
    send_byte(8'h00, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    n = 0;
    while (!tx_valid && n < TO + 20) begin tick(1); n++; end
    checks++;
    if (n < TO - 2 || n > TO + 2) begin failures++; $display("FAIL timeout_delay got %0d cycles want %0d", n, TO); end
    wait_tx(5, r, ok);
    checks++;
    if (!ok || r !== 8'h15 || wr_addr.size() != 0 || busy !== 1'b0 || error !== 1'b1) begin
      failures++; $display("FAIL timeout_status tx=%h writes=%0d busy=%b err=%b want 15 0 0 1", r, wr_addr.size(), busy, error);
    end
  endtask

  task automatic test_backpressure();
    int bad; logic [7:0] r; bit ok;
    load_frame1(); clear_mon(); tx_ready = 1'b0;
    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_frame(1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) bad++;
      tick(1);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold unstable=%0d cycles want 0 (tx_valid=%b tx_data=%h)", bad, tx_valid, tx_data); end
    tx_ready = 1'b1; wait_tx(5, r, ok);
    checks++;
    if (!ok || r !== 8'h06 || wr_addr.size() != 2 || done !== 1'b1) begin
      failures++; $display("FAIL bp_result tx=%h writes=%0d done=%b want 06 2 1", r, wr_addr.size(), done);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r; bit ok;
    clear_mon();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0);
    rst_n = 1'b0; #2;
    checks++;
    if ({tx_valid, tx_data, mem_we, mem_sel, mem_addr, mem_wdata, busy, done, error, core_rst_n} !== 59'd0) begin
      failures++; $display("FAIL midreset_values busy=%b addr=%h wdata=%h done=%b err=%b want all 0", busy, mem_addr, mem_wdata, done, error);
    end
    tick(2); rst_n = 1'b1; tick(1);
    load_frame1(); clear_mon(); send_frame(0); wait_tx(20, r, ok);
    checks++;
    if (!ok || r !== 8'h06 || wr_addr.size() != 2 || done !== 1'b1 || core_rst_n !== 1'b1) begin
      failures++; $display("FAIL midreset_reload tx=%h writes=%0d done=%b core=%b want 06 2 1 1", r, wr_addr.size(), done, core_rst_n);
    end
    else begin
      checks++;
      if (wr_data[0] !== 32'h13 || wr_data[1] !== 32'h6F) begin
        failures++; $display("FAIL midreset_data got %h %h want 00000013 0000006f", wr_data[0], wr_data[1]);
      end
    end
  endtask

  task automatic test_max_len();
    int bad; logic [7:0] r; bit ok;
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back($urandom);
    build_frame(8'h01, 16'd1024, 8'h00); clear_mon(); send_frame(0); wait_tx(20, r, ok);
    checks++;
    if (!ok || r !== 8'h06 || wr_addr.size() != 1024) begin
      failures++; $display("FAIL maxlen tx=%h writes=%0d want 06 1024", r, wr_addr.size());
    end else begin
      bad = 0;
      foreach (exp_addr[i]) if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_sel[i] !== 1'b1) bad++;
      checks++;
      if (bad != 0 || wr_addr[1023] !== 12'hFFC) begin
        failures++; $display("FAIL maxlen_words mismatched=%0d last_addr=%h want 0 ffc", bad, wr_addr[1023]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] tgt, bad, r; bit ok; int nw;
    for (int f = 0; f < 12; f++) begin
      tgt = ($urandom_range(0, 9) == 0) ? 8'h02 : 8'($urandom_range(0, 1));
      nw  = $urandom_range(0, 6);
`ifdef LOADER_CHECKSUM_EN
      bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
`else
      bad = 8'h00;
`endif
      words.delete();
      for (int i = 0; i < nw; i++) words.push_back($urandom);
      build_frame(tgt, 16'(nw), bad);
      if (tgt > 8'd1) fq = fq[0:1];
      clear_mon(); send_frame(4); wait_tx(30, r, ok);
      checks++;
      if (!ok || r !== (exp_ack ? 8'h06 : 8'h15)) begin
        failures++; $display("FAIL rand%0d_tx got %h want %h", f, r, exp_ack ? 8'h06 : 8'h15);
      end
      checks++;
      if (wr_addr.size() != exp_addr.size()) begin
        failures++; $display("FAIL rand%0d_nwrites got %0d want %0d", f, wr_addr.size(), exp_addr.size());
      end else foreach (exp_addr[i]) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i] || wr_sel[i] !== tgt[0]) begin
          failures++; $display("FAIL rand%0d_write%0d got %h=%h sel=%b want %h=%h sel=%b", f, i,
            wr_addr[i], wr_data[i], wr_sel[i], exp_addr[i], exp_data[i], tgt[0]);
        end
      end
      checks++;
      if (done !== exp_ack || error !== !exp_ack || core_rst_n !== exp_ack || busy !== 1'b0) begin
        failures++; $display("FAIL rand%0d_status done=%b err=%b core=%b busy=%b want %b %b %b 0", f,
          done, error, core_rst_n, busy, exp_ack, !exp_ack, exp_ack);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame1();
`ifdef LOADER_CHECKSUM_EN
    test_bad_cksum();
`endif
    test_len_too_big();
    test_bad_target();
    test_timeout();
    test_backpressure();
    test_random();
    test_max_len();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
